// File: rtl/raifes_regfile_mp_pkg.sv
// Shared constants for the multi-port integer register file: address width,
// default widths/counts and the state encoding used by the debug arbiter.
package raifes_regfile_mp_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int XPR_LEN        = 32;
   localparam bit ISA_EXT_E      = 1'b0;
   localparam int NREGS_DEFAULT  = ISA_EXT_E ? 16 : 32;

   localparam logic [1:0] RF_INIT    = 2'd0;
   localparam logic [1:0] RF_RUN     = 2'd1;
   localparam logic [1:0] RF_DM_ACC  = 2'd2;
   localparam logic [1:0] RF_DM_DONE = 2'd3;

   // Register 0 and anything at or above the register count are not storage.
   function automatic logic addr_valid(input logic [REG_ADDR_WIDTH-1:0] a,
                                       input logic [5:0] nregs);
      return (a != '0) && ({1'b0, a} < nregs);
   endfunction

endpackage

// File: rtl/raifes_regfile_mp_if.sv
// Debug-module access port: 4-phase level handshake (req held until ack,
// ack falls once req drops); we/addr/wd are stable while req is high.
interface raifes_regfile_mp_if #(
   parameter int XLEN = 32
);
   logic            dm_req;
   logic            dm_we;
   logic [4:0]      dm_addr;
   logic [XLEN-1:0] dm_wd;
   logic            dm_ack;
   logic [XLEN-1:0] dm_rd;
   logic            dm_err;

   modport master (output dm_req, dm_we, dm_addr, dm_wd,
                   input  dm_ack, dm_rd, dm_err);
   modport slave  (input  dm_req, dm_we, dm_addr, dm_wd,
                   output dm_ack, dm_rd, dm_err);
endinterface

// File: rtl/raifes_regfile_mp_dmarb.sv
// Debug access FSM and array write arbiter: picks between the clear sequence,
// core writes and deferred debug writes so that a core write is never lost.
module raifes_regfile_dmarb
   import raifes_regfile_mp_pkg::*;
#(
   parameter int XLEN       = XPR_LEN,
   parameter int NREGS      = NREGS_DEFAULT,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_wen,
   input  logic [REG_ADDR_WIDTH-1:0] i_wa,
   input  logic [XLEN-1:0]           i_wd,
   input  logic [REG_ADDR_WIDTH-1:0] i_init_cnt,
   input  logic                      i_init_last,
   input  logic [XLEN-1:0]           i_lat_rdata,
   raifes_regfile_mp_if.slave        dm,
   output logic                      o_core_ok,
   output logic                      o_arr_we,
   output logic [REG_ADDR_WIDTH-1:0] o_arr_wa,
   output logic [XLEN-1:0]           o_arr_wd,
   output logic [REG_ADDR_WIDTH-1:0] o_lat_addr,
   output logic [1:0]                o_state
);
   localparam logic [5:0] NREGS_W = 6'(NREGS);

   logic [1:0]                r_state;
   logic                      r_we;
   logic [REG_ADDR_WIDTH-1:0] r_addr;
   logic [XLEN-1:0]           r_wd;
   logic                      r_ack;
   logic [XLEN-1:0]           r_rd;
   logic                      r_err;
   logic                      w_core_we;
   logic                      w_dm_go;
   logic                      w_dm_we;

   assign o_state    = r_state;
   assign o_lat_addr = r_addr;
   assign o_core_ok  = (r_state != RF_INIT);
   assign dm.dm_ack  = r_ack;
   assign dm.dm_rd   = r_rd;
   assign dm.dm_err  = r_err;

   // A pending debug write yields to any core write in the same cycle.
   assign w_core_we = i_wen && o_core_ok && addr_valid(i_wa, NREGS_W);
   assign w_dm_go   = (r_state == RF_DM_ACC) && !(r_we && i_wen);
   assign w_dm_we   = w_dm_go && r_we && addr_valid(r_addr, NREGS_W);

   always_comb begin
      o_arr_we = 1'b0;
      o_arr_wa = i_wa;
      o_arr_wd = i_wd;
      if (r_state == RF_INIT) begin
         o_arr_we = 1'b1;
         o_arr_wa = i_init_cnt;
         o_arr_wd = '0;
      end else if (w_core_we) begin
         o_arr_we = 1'b1;
      end else if (w_dm_we) begin
         o_arr_we = 1'b1;
         o_arr_wa = r_addr;
         o_arr_wd = r_wd;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= INIT_CLEAR ? RF_INIT : RF_RUN;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wd    <= '0;
         r_ack   <= 1'b0;
         r_rd    <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            RF_INIT: begin
               if (i_init_last) r_state <= RF_RUN;
            end
            RF_RUN: begin
               if (dm.dm_req) begin
                  r_we    <= dm.dm_we;
                  r_addr  <= dm.dm_addr;
                  r_wd    <= dm.dm_wd;
                  r_state <= RF_DM_ACC;
               end
            end
            RF_DM_ACC: begin
               if (w_dm_go) begin
                  r_rd    <= r_we ? '0 : i_lat_rdata;
                  r_err   <= ({1'b0, r_addr} >= NREGS_W);
                  r_ack   <= 1'b1;
                  r_state <= RF_DM_DONE;
               end
            end
            default: begin
               if (!dm.dm_req) begin
                  r_ack   <= 1'b0;
                  r_state <= RF_RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/raifes_regfile_mp.sv
// Integer register file: two combinational read ports, one core write port,
// post-reset zero clear of the unreset array and a debug access port.
module raifes_regfile_mp
   import raifes_regfile_mp_pkg::*;
#(
   parameter int XLEN       = XPR_LEN,
   parameter int NREGS      = NREGS_DEFAULT,
   parameter bit BYPASS     = 1'b1,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [REG_ADDR_WIDTH-1:0] ra1,
   output logic [XLEN-1:0]           rd1,
   input  logic [REG_ADDR_WIDTH-1:0] ra2,
   output logic [XLEN-1:0]           rd2,
   input  logic                      wen,
   input  logic [REG_ADDR_WIDTH-1:0] wa,
   input  logic [XLEN-1:0]           wd,
   raifes_regfile_mp_if.slave        dm,
   output logic                      init_busy,
   output logic [1:0]                o_dbg_state
);
   localparam int         AW      = $clog2(NREGS);
   localparam logic [5:0] NREGS_W = 6'(NREGS);

   logic [XLEN-1:0]           r_array [NREGS];
   logic [REG_ADDR_WIDTH-1:0] r_cnt;
   logic                      w_core_ok;
   logic                      w_core_wr;
   logic                      w_init_last;
   logic                      w_arr_we;
   logic [REG_ADDR_WIDTH-1:0] w_arr_wa;
   logic [XLEN-1:0]           w_arr_wd;
   logic [REG_ADDR_WIDTH-1:0] w_lat_addr;
   logic [XLEN-1:0]           w_lat_rdata;

   assign init_busy   = (o_dbg_state == RF_INIT);
   assign w_init_last = init_busy && (r_cnt == REG_ADDR_WIDTH'(NREGS - 1));
   assign w_core_wr   = wen && w_core_ok;

   // Shared by both core ports and the debug read so all three agree.
   function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR_WIDTH-1:0] a);
      if (!addr_valid(a, NREGS_W) || init_busy) return '0;
      if (BYPASS && w_core_wr && (wa == a)) return wd;
      return r_array[AW'(a)];
   endfunction

   always_comb rd1         = read_port(ra1);
   always_comb rd2         = read_port(ra2);
   always_comb w_lat_rdata = read_port(w_lat_addr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_cnt <= 5'd1;
      else if (init_busy && !w_init_last) r_cnt <= r_cnt + 5'd1;
   end

   always_ff @(posedge clk) begin
      if (w_arr_we) r_array[AW'(w_arr_wa)] <= w_arr_wd;
   end

   raifes_regfile_dmarb #(
      .XLEN       (XLEN),
      .NREGS      (NREGS),
      .INIT_CLEAR (INIT_CLEAR)
   ) u_dmarb (
      .clk         (clk),
      .reset       (reset),
      .i_wen       (wen),
      .i_wa        (wa),
      .i_wd        (wd),
      .i_init_cnt  (r_cnt),
      .i_init_last (w_init_last),
      .i_lat_rdata (w_lat_rdata),
      .dm          (dm),
      .o_core_ok   (w_core_ok),
      .o_arr_we    (w_arr_we),
      .o_arr_wa    (w_arr_wa),
      .o_arr_wd    (w_arr_wd),
      .o_lat_addr  (w_lat_addr),
      .o_state     (o_dbg_state)
   );

endmodule

// File: tb/tb_raifes_regfile_mp.sv
// Directed bench driving two instances in lockstep: u_a (32 regs, bypass on)
// and u_b (16 regs, bypass off); expected values are hand-derived constants.
module tb_raifes_regfile_mp;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  ra1 = '0, ra2 = '0, wa = '0;
   logic        wen = 1'b0;
   logic [31:0] wd = '0;
   logic        dm_req = 1'b0, dm_we = 1'b0;
   logic [4:0]  dm_addr = '0;
   logic [31:0] dm_wd = '0;

   logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic        busy_a, busy_b;
   logic [1:0]  st_a, st_b;

   int checks = 0;
   int failures = 0;

   raifes_regfile_mp_if #(.XLEN(32)) dm_a ();
   raifes_regfile_mp_if #(.XLEN(32)) dm_b ();

   assign dm_a.dm_req = dm_req;  assign dm_b.dm_req = dm_req;
   assign dm_a.dm_we = dm_we;    assign dm_b.dm_we = dm_we;
   assign dm_a.dm_addr = dm_addr; assign dm_b.dm_addr = dm_addr;
   assign dm_a.dm_wd = dm_wd;    assign dm_b.dm_wd = dm_wd;

   raifes_regfile_mp #(.XLEN(32), .NREGS(32), .BYPASS(1'b1), .INIT_CLEAR(1'b1)) u_a (
      .clk(clk), .reset(reset), .ra1(ra1), .rd1(rd1_a), .ra2(ra2), .rd2(rd2_a),
      .wen(wen), .wa(wa), .wd(wd), .dm(dm_a), .init_busy(busy_a), .o_dbg_state(st_a));

   raifes_regfile_mp #(.XLEN(32), .NREGS(16), .BYPASS(1'b0), .INIT_CLEAR(1'b1)) u_b (
      .clk(clk), .reset(reset), .ra1(ra1), .rd1(rd1_b), .ra2(ra2), .rd2(rd2_b),
      .wen(wen), .wa(wa), .wd(wd), .dm(dm_b), .init_busy(busy_b), .o_dbg_state(st_b));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_reset();
      int cyc;
      int cyc_b;
      dm_req = 1'b0;
      wen = 1'b0;
      reset = 1'b1;
      step();
      check("rst_busy", {busy_a, busy_b}, 2'b11);
      check("rst_ack", {dm_a.dm_ack, dm_b.dm_ack}, 2'b00);
      check("rst_dm_rd_a", dm_a.dm_rd, 32'h0);
      check("rst_state_a", st_a, 2'd0);
      reset = 1'b0;
      cyc = 0;
      cyc_b = 0;
      while (busy_a && cyc < 100) begin
         step();
         cyc++;
         if (!busy_b && cyc_b == 0) cyc_b = cyc;
      end
      check("init_cycles_a", cyc, 31);
      check("init_cycles_b", cyc_b, 15);
      check("run_state", {st_a, st_b}, {2'd1, 2'd1});
   endtask

   task automatic dm_start(input logic we, input logic [4:0] addr, input logic [31:0] d);
      int n;
      dm_we = we;
      dm_addr = addr;
      dm_wd = d;
      dm_req = 1'b1;
      n = 0;
      while (!(dm_a.dm_ack && dm_b.dm_ack) && n < 10) begin
         step();
         n++;
      end
      check("dm_ack_wait", {dm_a.dm_ack, dm_b.dm_ack}, 2'b11);
      check("dm_ack_latency", n, 2);
   endtask

   task automatic dm_end();
      dm_req = 1'b0;
      step();
      check("dm_ack_drop", {dm_a.dm_ack, dm_b.dm_ack}, 2'b00);
   endtask

   task automatic core_write(input logic [4:0] a, input logic [31:0] d);
      wen = 1'b1;
      wa = a;
      wd = d;
      step();
      wen = 1'b0;
   endtask

   initial begin
      #3;
      run_reset();
      for (int i = 1; i < 32; i++) begin
         ra1 = 5'(i);
         #1;
         check("clear_a", rd1_a, 32'h0);
         if (i < 16) check("clear_b", rd1_b, 32'h0);
      end

      // same-cycle bypass versus registered visibility
      ra1 = 5'd5;
      wen = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
      #1;
      check("bypass_a", rd1_a, 32'hDEADBEEF);
      check("nobypass_b", rd1_b, 32'h0);
      step();
      wen = 1'b0;
      #1;
      check("after_wr_a", rd1_a, 32'hDEADBEEF);
      check("after_wr_b", rd1_b, 32'hDEADBEEF);

      // debug write deferred behind three conflicting core writes
      ra2 = 5'd9;
      dm_we = 1'b1; dm_addr = 5'd7; dm_wd = 32'h12345678; dm_req = 1'b1;
      step();
      check("acc_state_a", st_a, 2'd2);
      for (int k = 1; k <= 3; k++) begin
         wen = 1'b1; wa = 5'd9; wd = 32'h900 + 32'(k);
         step();
         check("conflict_ack", {dm_a.dm_ack, dm_b.dm_ack}, 2'b00);
         check("conflict_wr_b", rd2_b, 32'h900 + 32'(k));
         check("conflict_state_b", st_b, 2'd2);
      end
      wen = 1'b0;
      step();
      check("defer_ack", {dm_a.dm_ack, dm_b.dm_ack}, 2'b11);
      check("done_state_a", st_a, 2'd3);
      ra1 = 5'd7;
      #1;
      check("dm_wr_a", rd1_a, 32'h12345678);
      check("dm_wr_b", rd1_b, 32'h12345678);
      check("core9_a", rd2_a, 32'h903);
      dm_end();
      check("back_run_a", st_a, 2'd1);

      // out-of-range debug read on the 16-register instance
      core_write(5'd20, 32'hA5A50014);
      ra1 = 5'd20;
      #1;
      check("wr20_a", rd1_a, 32'hA5A50014);
      check("wr20_dropped_b", rd1_b, 32'h0);
      dm_start(1'b0, 5'd20, 32'h0);
      check("dm_rd20_a", dm_a.dm_rd, 32'hA5A50014);
      check("dm_err20_a", dm_a.dm_err, 1'b0);
      check("dm_rd20_b", dm_b.dm_rd, 32'h0);
      check("dm_err20_b", dm_b.dm_err, 1'b1);
      dm_end();

      // debug write to register 0 is acknowledged but has no effect
      dm_start(1'b1, 5'd0, 32'hFFFFFFFF);
      check("dm_err0", {dm_a.dm_err, dm_b.dm_err}, 2'b00);
      dm_end();
      ra1 = 5'd0;
      #1;
      check("r0_a", rd1_a, 32'h0);
      check("r0_b", rd1_b, 32'h0);

      dm_start(1'b0, 5'd9, 32'h0);
      check("dm_rd9_a", dm_a.dm_rd, 32'h903);
      check("dm_rd9_b", dm_b.dm_rd, 32'h903);
      dm_end();

      // debug read sees a same-cycle core write to the same register
      dm_we = 1'b0; dm_addr = 5'd12; dm_req = 1'b1;
      step();
      wen = 1'b1; wa = 5'd12; wd = 32'h0000C0DE;
      step();
      wen = 1'b0;
      check("dm_byp_ack_a", dm_a.dm_ack, 1'b1);
      check("dm_byp_rd_a", dm_a.dm_rd, 32'h0000C0DE);
      dm_end();

      // core writes to register 0 and to register 17
      core_write(5'd0, 32'h0000FFFF);
      core_write(5'd17, 32'h00001717);
      ra1 = 5'd0; ra2 = 5'd17;
      #1;
      check("core_r0_a", rd1_a, 32'h0);
      check("core_r0_b", rd1_b, 32'h0);
      check("core_r17_a", rd2_a, 32'h00001717);
      check("core_r17_b", rd2_b, 32'h0);

      // reset during DM_DONE drops ack at once
      dm_start(1'b0, 5'd9, 32'h0);
      check("pre_rst_rd_b", dm_b.dm_rd, 32'h903);
      reset = 1'b1;
      #1;
      check("async_ack_drop", {dm_a.dm_ack, dm_b.dm_ack}, 2'b00);
      check("async_rd_clr_a", dm_a.dm_rd, 32'h0);
      check("async_busy", {busy_a, busy_b}, 2'b11);
      dm_req = 1'b0;
      step();
      reset = 1'b0;

      // reset again during the clear, with the counter at 10
      repeat (9) step();
      check("mid_init_busy_a", busy_a, 1'b1);
      run_reset();

      ra1 = 5'd5;  #1; check("post_clr5_a", rd1_a, 32'h0);  check("post_clr5_b", rd1_b, 32'h0);
      ra1 = 5'd7;  #1; check("post_clr7_a", rd1_a, 32'h0);  check("post_clr7_b", rd1_b, 32'h0);
      ra1 = 5'd9;  #1; check("post_clr9_a", rd1_a, 32'h0);  check("post_clr9_b", rd1_b, 32'h0);
      ra1 = 5'd12; #1; check("post_clr12_a", rd1_a, 32'h0);
      ra1 = 5'd17; #1; check("post_clr17_a", rd1_a, 32'h0);
      ra1 = 5'd20; #1; check("post_clr20_a", rd1_a, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
